// File: rtl/lvds_7to1_tx_framer.sv
// 7:1 LVDS transmit framer: clock-lane pattern plus four data lanes carrying
// training, blanking guard, then VESA/JEIDA-mapped RGB pixels with sync/DE.
module lvds_7to1_tx_framer #(
  parameter logic [6:0] CLK_PT     = 7'b1100011,
  parameter logic [6:0] TRAIN_WORD = 7'b1010101,
  parameter int         TRAIN_LEN  = 1024,
  parameter int         GUARD_LEN  = 4,
  parameter bit         MAP_JEIDA  = 1'b0
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        tx_enable,
  input  logic        train_req,
  input  logic        pix_valid,
  output logic        pix_ready,
  input  logic [23:0] pix_rgb,
  input  logic        pix_hs,
  input  logic        pix_vs,
  input  logic        pix_de,
  output logic [6:0]  clock_word,
  output logic [6:0]  data_word0,
  output logic [6:0]  data_word1,
  output logic [6:0]  data_word2,
  output logic [6:0]  data_word3,
  output logic        link_up,
  output logic [15:0] underflow_cnt
);

  localparam int          NUM_LANES  = 4;
  localparam logic [15:0] TRAIN_LAST = 16'(TRAIN_LEN - 1);
  localparam logic [15:0] GUARD_LAST = 16'(GUARD_LEN - 1);

  typedef enum logic [1:0] {IDLE, TRAIN, GUARD, RUN} state_t;

  state_t                     state;
  logic [15:0]                cnt;
  logic                       hs_q, vs_q;
  logic [NUM_LANES-1:0][6:0]  pix_map, blank_map, lane_q;
  logic [7:0]                 r, g, b;
  logic                       accept;

  assign {r, g, b} = pix_rgb;
  assign pix_ready = (state == RUN) && tx_enable && !train_req;
  assign accept    = pix_ready && pix_valid;

  assign data_word0 = lane_q[0];
  assign data_word1 = lane_q[1];
  assign data_word2 = lane_q[2];
  assign data_word3 = lane_q[3];

  // JEIDA puts the colour MSBs on lanes 0-2 so 6-bit sinks can ignore lane 3;
  // VESA puts them on lane 3 instead.
  always_comb begin
    pix_map = '0;
    if (MAP_JEIDA) begin
      pix_map[0] = {g[2], r[7:2]};
      pix_map[1] = {b[3:2], g[7:3]};
      pix_map[2] = {pix_de, pix_vs, pix_hs, b[7:4]};
      pix_map[3] = {1'b0, b[1:0], g[1:0], r[1:0]};
    end else begin
      pix_map[0] = {g[0], r[5:0]};
      pix_map[1] = {b[1:0], g[5:1]};
      pix_map[2] = {pix_de, pix_vs, pix_hs, b[5:2]};
      pix_map[3] = {1'b0, b[7:6], g[7:6], r[7:6]};
    end
    blank_map    = '0;
    blank_map[2] = {1'b0, vs_q, hs_q, 4'b0000};
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state         <= IDLE;
      cnt           <= '0;
      hs_q          <= 1'b0;
      vs_q          <= 1'b0;
      lane_q        <= '0;
      clock_word    <= '0;
      link_up       <= 1'b0;
      underflow_cnt <= '0;
    end else begin
      clock_word <= CLK_PT;
      link_up    <= (state == RUN);

      // Lane words follow the state of this cycle, one cycle late.
      case (state)
        IDLE:    lane_q <= '0;
        TRAIN:   lane_q <= {NUM_LANES{TRAIN_WORD}};
        GUARD:   lane_q <= blank_map;
        RUN:     lane_q <= accept ? pix_map : blank_map;
        default: lane_q <= '0;
      endcase

      if (accept) begin
        hs_q <= pix_hs;
        vs_q <= pix_vs;
      end

      if (pix_ready && !pix_valid && underflow_cnt != 16'hFFFF)
        underflow_cnt <= underflow_cnt + 16'd1;

      // Transitions; later assignments here override the datapath updates above.
      if (!tx_enable) begin
        state <= IDLE;
        cnt   <= '0;
      end else if (train_req || state == IDLE) begin
        state         <= TRAIN;
        cnt           <= '0;
        hs_q          <= 1'b0;
        vs_q          <= 1'b0;
        underflow_cnt <= '0;
      end else begin
        case (state)
          TRAIN: begin
            if (cnt == TRAIN_LAST) begin
              state <= GUARD;
              cnt   <= '0;
            end else begin
              cnt <= cnt + 16'd1;
            end
          end
          GUARD: begin
            if (cnt == GUARD_LAST) begin
              state <= RUN;
              cnt   <= '0;
            end else begin
              cnt <= cnt + 16'd1;
            end
          end
          default: state <= state;
        endcase
      end
    end
  end

endmodule

// File: tb/tb_lvds_7to1_tx_framer.sv
// Directed bench: VESA and JEIDA framers driven in lockstep through training,
// pixel mapping, underflow saturation, retrain and disable race.
module tb_lvds_7to1_tx_framer;

  logic        clk, rst, tx_enable, train_req, pix_valid;
  logic [23:0] pix_rgb;
  logic        pix_hs, pix_vs, pix_de;

  logic        v_ready, j_ready, v_link, j_link;
  logic [6:0]  v_cw, j_cw;
  logic [6:0]  v_d [4];
  logic [6:0]  j_d [4];
  logic [15:0] v_uf, j_uf;

  int tests = 0;
  int fails = 0;

  lvds_7to1_tx_framer #(.TRAIN_LEN(8), .GUARD_LEN(2), .MAP_JEIDA(1'b0)) dut_v (
    .clk(clk), .rst(rst), .tx_enable(tx_enable), .train_req(train_req),
    .pix_valid(pix_valid), .pix_ready(v_ready), .pix_rgb(pix_rgb),
    .pix_hs(pix_hs), .pix_vs(pix_vs), .pix_de(pix_de), .clock_word(v_cw),
    .data_word0(v_d[0]), .data_word1(v_d[1]), .data_word2(v_d[2]),
    .data_word3(v_d[3]), .link_up(v_link), .underflow_cnt(v_uf));

  lvds_7to1_tx_framer #(.TRAIN_LEN(8), .GUARD_LEN(2), .MAP_JEIDA(1'b1)) dut_j (
    .clk(clk), .rst(rst), .tx_enable(tx_enable), .train_req(train_req),
    .pix_valid(pix_valid), .pix_ready(j_ready), .pix_rgb(pix_rgb),
    .pix_hs(pix_hs), .pix_vs(pix_vs), .pix_de(pix_de), .clock_word(j_cw),
    .data_word0(j_d[0]), .data_word1(j_d[1]), .data_word2(j_d[2]),
    .data_word3(j_d[3]), .link_up(j_link), .underflow_cnt(j_uf));

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic logic [31:0] w4(input logic [6:0] l3, l2, l1, l0);
    return {4'h0, l3, l2, l1, l0};
  endfunction

  function automatic logic [31:0] vl();
    return {4'h0, v_d[3], v_d[2], v_d[1], v_d[0]};
  endfunction

  function automatic logic [31:0] jl();
    return {4'h0, j_d[3], j_d[2], j_d[1], j_d[0]};
  endfunction

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic pix(input logic [23:0] rgb, input logic hs, vs, de);
    pix_valid = 1'b1;
    pix_rgb   = rgb;
    pix_hs    = hs;
    pix_vs    = vs;
    pix_de    = de;
  endtask

  initial begin
    logic [31:0] exp_d;
    rst = 1'b1; tx_enable = 1'b0; train_req = 1'b0; pix_valid = 1'b0;
    pix_rgb = '0; pix_hs = 1'b0; pix_vs = 1'b0; pix_de = 1'b0;
    step();
    step();

    check("rst_clock_word", 32'(v_cw), 32'h0);
    check("rst_data_v", vl(), 32'h0);
    check("rst_data_j", jl(), 32'h0);
    check("rst_ready", 32'(v_ready), 32'h0);
    check("rst_link", 32'(v_link), 32'h0);
    check("rst_underflow", 32'(v_uf), 32'h0);

    // Cycle 0: release reset, enable, and present a VESA test pixel early.
    rst = 1'b0;
    tx_enable = 1'b1;
    pix(24'hFF0000, 1'b1, 1'b0, 1'b1);
    for (int cyc = 1; cyc <= 11; cyc++) begin
      step();
      exp_d = (cyc >= 2 && cyc <= 9) ? w4(7'h55, 7'h55, 7'h55, 7'h55) : 32'h0;
      check($sformatf("en_data_v_c%0d", cyc), vl(), exp_d);
      check($sformatf("en_data_j_c%0d", cyc), jl(), exp_d);
      check($sformatf("en_clock_word_c%0d", cyc), 32'(v_cw), 32'h63);
      check($sformatf("en_ready_c%0d", cyc), 32'(v_ready), (cyc >= 11) ? 32'h1 : 32'h0);
      check($sformatf("en_link_c%0d", cyc), 32'(v_link), 32'h0);
    end

    step();  // cycle 12: FF0000 accepted at 11
    check("c12_link", 32'(v_link), 32'h1);
    check("vesa_ff0000", vl(), w4(7'h03, 7'h50, 7'h00, 7'h3F));
    check("jeida_ff0000", jl(), w4(7'h03, 7'h50, 7'h00, 7'h3F));
    pix(24'h0000FF, 1'b0, 1'b0, 1'b1);

    step();
    check("vesa_0000ff", vl(), w4(7'h30, 7'h4F, 7'h60, 7'h00));
    check("jeida_0000ff", jl(), w4(7'h30, 7'h4F, 7'h60, 7'h00));
    pix(24'h123456, 1'b0, 1'b1, 1'b1);

    step();
    check("vesa_123456", vl(), w4(7'h10, 7'h65, 7'h5A, 7'h12));
    check("jeida_123456", jl(), w4(7'h22, 7'h65, 7'h26, 7'h44));
    pix(24'h000000, 1'b1, 1'b0, 1'b0);

    step();
    check("de0_pixel_v", vl(), w4(7'h00, 7'h10, 7'h00, 7'h00));
    check("de0_no_underflow", 32'(v_uf), 32'h0);
    pix_valid = 1'b0;

    for (int i = 0; i < 5; i++) step();
    check("underflow_5_v", 32'(v_uf), 32'h5);
    check("underflow_5_j", 32'(j_uf), 32'h5);
    check("blank_holds_hs", vl(), w4(7'h00, 7'h10, 7'h00, 7'h00));
    check("ready_while_starved", 32'(v_ready), 32'h1);

    for (int i = 0; i < 70000; i++) step();
    check("underflow_sat", 32'(v_uf), 32'hFFFF);

    // Retrain request with a valid pixel: must not be accepted.
    pix(24'h123456, 1'b0, 1'b1, 1'b1);
    train_req = 1'b1;
    #1;
    check("retrain_ready_low", 32'(v_ready), 32'h0);
    step();
    train_req = 1'b0;
    pix_valid = 1'b0;
    check("retrain_pixel_dropped", vl(), w4(7'h00, 7'h10, 7'h00, 7'h00));
    check("retrain_underflow_clr", 32'(v_uf), 32'h0);
    check("retrain_link_lag", 32'(v_link), 32'h1);
    step();
    check("retrain_train_word", vl(), w4(7'h55, 7'h55, 7'h55, 7'h55));
    check("retrain_link_down", 32'(v_link), 32'h0);

    // Disable and train request together: IDLE wins.
    tx_enable = 1'b0;
    train_req = 1'b1;
    step();
    train_req = 1'b0;
    step();
    check("race_data_zero_v", vl(), 32'h0);
    check("race_data_zero_j", jl(), 32'h0);
    check("race_clock_word", 32'(v_cw), 32'h63);
    check("race_ready", 32'(v_ready), 32'h0);

    // Reset mid-operation returns clock_word to 0 as well.
    tx_enable = 1'b1;
    step();
    rst = 1'b1;
    step();
    check("midreset_clock_word", 32'(v_cw), 32'h0);
    check("midreset_data", vl(), 32'h0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
